// File: rtl/ssd_ahb_write_arbiter.sv
// ssd_ahb_write_arbiter
// Arbitrates two 6-bit requesters (classifier, switch) onto a single AHB-Lite
// write to the SSD data/mode register. Identical back-to-back payloads are
// acknowledged without a bus transfer. A stalled bus phase times out into a
// sticky error, and an error response also sets that sticky error.
module ssd_ahb_write_arbiter #(
    parameter logic [31:0] SSD_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic        req0,
    input  logic [5:0]  data0,
    input  logic        req1,
    input  logic [5:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] ahb_m_haddr,
    output logic [1:0]  ahb_m_htrans,
    output logic        ahb_m_hwrite,
    output logic [2:0]  ahb_m_hsize,
    output logic [31:0] ahb_m_hwdata,
    input  logic        ahb_m_hready_i,
    input  logic        ahb_m_hresp_i,
    output logic        busy,
    output logic        err,
    output logic        last_src
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       payload, payload_nxt;
    logic [5:0]       last_written, last_written_nxt;
    logic             last_valid, last_valid_nxt;
    logic             last_src_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
    logic             pick;
    logic [5:0]       data_sel;
    logic             timeout_hit;

    // Write data always mirrors the payload register; reset clears both.
    assign ahb_m_hwdata = {26'b0, payload};
    assign busy         = (state != IDLE);
    // The requester being acknowledged is the one granted most recently.
    assign ack0         = (state == DONE) && !last_src;
    assign ack1         = (state == DONE) &&  last_src;
    assign timeout_hit  = !ahb_m_hready_i && (to_cnt == CNT_LAST);

    // Next-state, datapath updates and AHB address-phase outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt        = state;
        payload_nxt      = payload;
        last_written_nxt = last_written;
        last_valid_nxt   = last_valid;
        last_src_nxt     = last_src;
        err_nxt          = err;
        to_cnt_nxt       = '0;
        pick             = 1'b0;
        data_sel         = data0;
        ahb_m_haddr      = 32'h0;
        ahb_m_htrans     = 2'b00;
        ahb_m_hwrite     = 1'b0;
        ahb_m_hsize      = 3'b000;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie, serve whichever requester was not served last.
                    pick         = (req0 && req1) ? !last_src : req1;
                    data_sel     = pick ? data1 : data0;
                    payload_nxt  = data_sel;
                    last_src_nxt = pick;
                    state_nxt    = (last_valid && (data_sel == last_written)) ? DONE : ADDR;
                end
            end
            ADDR: begin
                ahb_m_haddr  = SSD_ADDR;
                ahb_m_htrans = 2'b10;
                ahb_m_hwrite = 1'b1;
                ahb_m_hsize  = 3'b010;
                if (ahb_m_hready_i) begin
                    state_nxt = DATA;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    to_cnt_nxt = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1;
                end
            end
            DATA: begin
                if (ahb_m_hready_i) begin
                    state_nxt = DONE;
                    if (ahb_m_hresp_i) begin
                        err_nxt = 1'b1;
                    end else begin
                        last_written_nxt = payload;
                        last_valid_nxt   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    to_cnt_nxt = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset on btnC.
    always_ff @(posedge clk) begin
        // NOTE: the reset also clears payload and last_written, so the bus
        // data returns to zero and duplicate suppression restarts cleanly.
        if (btnC) begin
            state        <= IDLE;
            payload      <= '0;
            last_written <= '0;
            last_valid   <= 1'b0;
            last_src     <= 1'b1;
            err          <= 1'b0;
            to_cnt       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from the same pre-edge values, independent of statement order.
            state        <= state_nxt;
            payload      <= payload_nxt;
            last_written <= last_written_nxt;
            last_valid   <= last_valid_nxt;
            last_src     <= last_src_nxt;
            err          <= err_nxt;
            to_cnt       <= to_cnt_nxt;
        end
    end

endmodule
